fpu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares one combinational single-precision fpu adder between two requesters. It accepts an operand pair from one requester at a time over a valid/ready handshake, round-robin when both are requesting. It registers the operands onto the fpu inputs and waits a fixed settle time. It then captures the sum and overflow flag and returns them on a single response channel tagged with the requester ID. It sits between client blocks and the fpu instance and holds the adder stable for the whole operation.

---
 rtl/fpu_share_ctrl.sv | 126 ++++++++++++
 tb/tb_fpu_share_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_ctrl.sv
// Shares one combinational fpu adder between two requesters: round-robin grant,
// registered operand launch, fixed settle wait, then a tagged response.
module fpu_share_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    input  logic [31:0] fpu_out,
    input  logic        fpu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        ptr;
    logic        grant;
    logic        accept;
    logic [7:0]  cnt;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_sub;

    // The pointer only breaks ties; a lone requester is always granted.
    always_comb begin
        grant = ptr;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_sub = grant ? req1_sub : req0_sub;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)      next_state = SETTLE;
            SETTLE:  if (cnt == 8'd0) next_state = RESP;
            RESP:    if (rsp_ready)   next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands stay on the fpu inputs from launch until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_in1   <= 32'h0;
            fpu_in2   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_ovf   <= 1'b0;
            ptr       <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_in1 <= sel_a;
                        fpu_in2 <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
                        rsp_id  <= grant;
                        ptr     <= ~grant;
                        cnt     <= 8'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rsp_data  <= fpu_out;
                        rsp_ovf   <= fpu_overflow;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Bench for fpu_share_ctrl: a behavioural fpu adder feeds the DUT, and a
// scoreboard queue holds the expected response for every accepted operation.
module tb_fpu_share_ctrl;

    localparam int SETTLE = 2;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic [31:0] fpu_in1, fpu_in2, fpu_out;
    logic        fpu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [31:0] rsp_data;

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    fpu_share_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_out(fpu_out),
        .fpu_overflow(fpu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Truncating single-precision adder; denormals read as zero, exponent
    // overflow gives a zero sum with the flag set.
    function automatic logic [32:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [25:0] ma, mb, m;
        int          ea, eb, e, sh;
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else begin a = y; b = x; end
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0) return 33'h0;
        if (eb == 0) return {1'b0, a};
        ma = {3'b001, a[22:0]};
        mb = {3'b001, b[22:0]};
        sh = ea - eb;
        mb = (sh > 25) ? 26'h0 : (mb >> sh);
        e  = ea;
        if (a[31] == b[31]) begin
            m = ma + mb;
            if (m[24]) begin m = m >> 1; e++; end
        end else begin
            m = ma - mb;
            if (m == '0) return 33'h0;
            for (int i = 0; i < 24 && !m[23]; i++) begin m = m << 1; e--; end
            if (e <= 0) return 33'h0;
        end
        if (e >= 255) return {1'b1, 32'h0};
        return {1'b0, a[31], 8'(e), m[22:0]};
    endfunction

    assign {fpu_overflow, fpu_out} = fadd(fpu_in1, fpu_in2);

    // Waits (from a negedge) for a handshake; queues the expected response.
    task automatic wait_accept(input int budget, output int id);
        logic [31:0] a, b;
        logic [32:0] r;
        id = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (req0_valid && req0_ready) id = 0;
            else if (req1_valid && req1_ready) id = 1;
            if (id >= 0) begin
                if (id == 0) begin a = req0_a; b = {req0_b[31] ^ req0_sub, req0_b[30:0]}; end
                else begin a = req1_a; b = {req1_b[31] ^ req1_sub, req1_b[30:0]}; end
                r = fadd(a, b);
                sb.push_back('{id: id[0], data: r[31:0], ovf: r[32]});
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int budget, output int edges);
        edges = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (rsp_valid) begin edges = i; return; end
            @(negedge clk);
        end
    endtask

    task automatic pop_exp(output exp_t ex);
        ex = '0;
        if (sb.size() != 0) ex = sb.pop_front();
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_ovf} !== 6'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_ovf});
        else passes++;
        checks++;
        if ({fpu_in1, fpu_in2, rsp_data} !== 96'h0)
            $display("[TB] FAIL reset_data: got %h %h %h expected zeros", fpu_in1, fpu_in2, rsp_data);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_basic();
        int   id, edges;
        exp_t ex;
        rsp_ready = 1'b1;
        req0_a = 32'h3FC00000; req0_b = 32'h3FC00000; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_accept(10, id);
        req0_valid = 1'b0;
        checks++;
        if (id !== 0) $display("[TB] FAIL basic_grant: got %0d expected 0", id); else passes++;
        #1;
        checks++;
        if ({req0_ready, busy} !== 2'b01)
            $display("[TB] FAIL basic_ready_busy: got %b expected 01", {req0_ready, busy});
        else passes++;
        checks++;
        if ({fpu_in1, fpu_in2} !== {32'h3FC00000, 32'h3FC00000})
            $display("[TB] FAIL basic_launch: got %h %h expected 3fc00000 3fc00000", fpu_in1, fpu_in2);
        else passes++;
        wait_rsp(20, edges);
        checks++;
        if (edges !== SETTLE) $display("[TB] FAIL basic_latency: got %0d expected %0d", edges, SETTLE);
        else passes++;
        pop_exp(ex);
        checks++;
        if ({busy, rsp_id, rsp_data, rsp_ovf} !== {1'b1, 1'b0, 32'h40400000, 1'b0})
            $display("[TB] FAIL basic_rsp: got busy=%b id=%b data=%h ovf=%b expected 1 0 40400000 0",
                     busy, rsp_id, rsp_data, rsp_ovf);
        else passes++;
        checks++;
        if ({rsp_id, rsp_data, rsp_ovf} !== {ex.id, ex.data, ex.ovf})
            $display("[TB] FAIL basic_sb: got %b %h %b expected %b %h %b",
                     rsp_id, rsp_data, rsp_ovf, ex.id, ex.data, ex.ovf);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00)
            $display("[TB] FAIL basic_release: got %b expected 00", {rsp_valid, busy});
        else passes++;
    endtask

    task automatic test_sub();
        int   id, edges;
        exp_t ex;
        req1_a = 32'h3FC00000; req1_b = 32'h3FC00000; req1_sub = 1'b1; req1_valid = 1'b1;
        wait_accept(10, id);
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({id[0], fpu_in2} !== {1'b1, 32'hBFC00000})
            $display("[TB] FAIL sub_launch: got id=%0d in2=%h expected 1 bfc00000", id, fpu_in2);
        else passes++;
        wait_rsp(20, edges);
        pop_exp(ex);
        checks++;
        if ({rsp_id, rsp_data, rsp_ovf} !== {1'b1, 32'h0, 1'b0})
            $display("[TB] FAIL sub_rsp: got %b %h %b expected 1 00000000 0", rsp_id, rsp_data, rsp_ovf);
        else passes++;
        checks++;
        if ({rsp_id, rsp_data} !== {ex.id, ex.data})
            $display("[TB] FAIL sub_sb: got %b %h expected %b %h", rsp_id, rsp_data, ex.id, ex.data);
        else passes++;
        @(negedge clk); #1;
    endtask

    task automatic test_round_robin();
        int   id, edges;
        exp_t ex;
        req0_a = 32'h40000000; req0_b = 32'h3F800000; req0_sub = 1'b0;
        req1_a = 32'h40800000; req1_b = 32'h40000000; req1_sub = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_accept(10, id);
            checks++;
            if (id !== (k % 2)) $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", k, id, k % 2);
            else passes++;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00)
                $display("[TB] FAIL rr_ready%0d: got %b expected 00", k, {req0_ready, req1_ready});
            else passes++;
            wait_rsp(20, edges);
            pop_exp(ex);
            checks++;
            if ({rsp_id, rsp_data} !== {ex.id, ex.data})
                $display("[TB] FAIL rr_rsp%0d: got %b %h expected %b %h", k, rsp_id, rsp_data, ex.id, ex.data);
            else passes++;
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0) $display("[TB] FAIL rr_bubble%0d: got busy=%b expected 0", k, busy);
            else passes++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_resp_hold();
        int   id, edges;
        exp_t ex;
        rsp_ready = 1'b0;
        req0_a = 32'h40400000; req0_b = 32'h3F800000; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_accept(10, id);
        req0_valid = 1'b0;
        req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0; req1_valid = 1'b1;
        wait_rsp(20, edges);
        pop_exp(ex);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_ovf} !== {1'b1, ex.id, 32'h40800000, ex.ovf})
                $display("[TB] FAIL hold_rsp%0d: got %b %b %h %b expected 1 %b 40800000 %b",
                         i, rsp_valid, rsp_id, rsp_data, rsp_ovf, ex.id, ex.ovf);
            else passes++;
            checks++;
            if ({req0_ready, req1_ready, busy} !== 3'b001)
                $display("[TB] FAIL hold_ready%0d: got %b expected 001", i, {req0_ready, req1_ready, busy});
            else passes++;
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, busy, req1_ready} !== 3'b001)
            $display("[TB] FAIL hold_release: got %b expected 001", {rsp_valid, busy, req1_ready});
        else passes++;
        req1_valid = 1'b0;
    endtask

    task automatic test_overflow();
        int   id, edges;
        exp_t ex;
        @(negedge clk);
        req1_a = 32'h7FC00000; req1_b = 32'h7FC00000; req1_sub = 1'b0; req1_valid = 1'b1;
        wait_accept(10, id);
        req1_valid = 1'b0;
        wait_rsp(20, edges);
        pop_exp(ex);
        checks++;
        if ({rsp_ovf, rsp_data} !== {1'b1, 32'h0})
            $display("[TB] FAIL ovf_rsp: got ovf=%b data=%h expected 1 00000000", rsp_ovf, rsp_data);
        else passes++;
        checks++;
        if ({rsp_id, rsp_ovf} !== {ex.id, ex.ovf})
            $display("[TB] FAIL ovf_sb: got %b %b expected %b %b", rsp_id, rsp_ovf, ex.id, ex.ovf);
        else passes++;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int   id, edges;
        exp_t ex;
        req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
        req1_a = 32'h40000000; req1_b = 32'h40000000; req1_sub = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_accept(10, id);
        req0_valid = 1'b0;
        checks++;
        if (id !== 0) $display("[TB] FAIL abort_first_grant: got %0d expected 0", id); else passes++;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_ovf, req0_ready, req1_ready, fpu_in1, fpu_in2, rsp_data} !== '0)
            $display("[TB] FAIL abort_clear: got busy=%b v=%b in1=%h in2=%h data=%h r1=%b expected zeros",
                     busy, rsp_valid, fpu_in1, fpu_in2, rsp_data, req1_ready);
        else passes++;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00)
            $display("[TB] FAIL abort_no_rsp: got %b expected 00", {rsp_valid, busy});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1;
        wait_accept(10, id);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (id !== 0) $display("[TB] FAIL abort_ptr_reset: got %0d expected 0", id); else passes++;
        wait_rsp(20, edges);
        pop_exp(ex);
        checks++;
        if ({rsp_id, rsp_data} !== {1'b0, 32'h40000000})
            $display("[TB] FAIL abort_rsp: got %b %h expected 0 40000000", rsp_id, rsp_data);
        else passes++;
        checks++;
        if (rsp_data !== ex.data) $display("[TB] FAIL abort_sb: got %h expected %h", rsp_data, ex.data);
        else passes++;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_sub();
        test_round_robin();
        test_resp_hold();
        test_overflow();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
